// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NREQ valid/ready sources, the arbiter and the FIFO write port.
// The master modport is the arbiter's view; slave is the sources/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int ASIZE = 10,
    parameter int IDW   = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic                  f_wen;
    logic [IDW+DSIZE-1:0]  f_wdata;
    logic                  f_full;
    logic [ASIZE-1:0]      f_wuse;

    modport master (
        input  req_valid, req_data, req_last, f_full, f_wuse,
        output req_ready, f_wen, f_wdata
    );

    modport slave (
        output req_valid, req_data, req_last, f_full, f_wuse,
        input  req_ready, f_wen, f_wdata
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NREQ sources.
// Each written word is tagged with its source ID in the upper IDW bits.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int ASIZE = 10,
    parameter int BURST = 16
) (
    input  logic              wclk,
    input  logic              rst_n,
    fifo_wr_arbiter_if.master bus,
    output logic [NREQ-1:0]   grant,
    output logic              busy
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(BURST + 1);
    localparam logic [ASIZE:0] DEPTH_W = {1'b1, {ASIZE{1'b0}}};
    localparam logic [ASIZE:0] BURST_W = (ASIZE+1)'(BURST);

    typedef enum logic {IDLE, XFER} state_t;

    state_t          state, state_nx;
    logic [IDW-1:0]  owner, rr, pick, cand;
    logic            pick_ok, space_ok, beat_acc, burst_end;
    logic [CW-1:0]   beat_cnt;

    // Pessimistic: f_wuse lags reads, so a full burst must fit against the stale count.
    assign space_ok = (({1'b0, bus.f_wuse} + BURST_W) <= DEPTH_W);
    assign beat_acc = bus.f_wen;

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            rr       <= IDW'(NREQ - 1);
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (state_nx == XFER) begin
                    owner    <= pick;
                    grant    <= NREQ'(1) << pick;
                    beat_cnt <= '0;
                end
                XFER: begin
                    if (burst_end) begin
                        rr    <= owner;
                        grant <= '0;
                    end else if (beat_acc) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // First valid source after the last-served one, wrapping.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        cand    = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IDW'((32'(rr) + i) % NREQ);
            if (!pick_ok && bus.req_valid[cand]) begin
                pick    = cand;
                pick_ok = 1'b1;
            end
        end
        burst_end = beat_acc && (bus.req_last[owner] || (beat_cnt == CW'(BURST - 1)));
        state_nx  = state;
        case (state)
            IDLE:    if (pick_ok && space_ok) state_nx = XFER;
            XFER:    if (burst_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.f_wen     = 1'b0;
        busy          = (state == XFER);
        if (state == XFER) begin
            bus.req_ready[owner] = ~bus.f_full;
            bus.f_wen            = bus.req_valid[owner] & ~bus.f_full;
        end
        bus.f_wdata = {owner, bus.req_data[owner*DSIZE +: DSIZE]};
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vector table, corner-case sequences,
// and randomized traffic against a cycle-level reference model.
module tb_fifo_wr_arbiter;
    localparam int NREQ  = 4;
    localparam int DSIZE = 8;
    localparam int ASIZE = 10;
    localparam int BURST = 16;
    localparam int IDW   = 2;
    localparam int DEPTH = 1 << ASIZE;

    logic            wclk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] grant;
    logic            busy;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE), .ASIZE(ASIZE), .IDW(IDW)) bus ();

    fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .ASIZE(ASIZE), .BURST(BURST)) dut (
        .wclk  (wclk),
        .rst_n (rst_n),
        .bus   (bus),
        .grant (grant),
        .busy  (busy)
    );

    always #5 wclk = ~wclk;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [3:0] v;
        logic [3:0] l;
        logic       f;
        int         wuse;
        logic [3:0] g;
        logic       b;
        logic [3:0] r;
        logic       w;
        logic [9:0] wd;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    function automatic logic [31:0] mk(logic [3:0] g, logic b, logic [3:0] r, logic w);
        return {22'b0, g, b, r, w};
    endfunction

    function automatic logic [31:0] outs();
        return {22'b0, grant, busy, bus.req_ready, bus.f_wen};
    endfunction

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic f, input int wuse);
        bus.req_valid = v;
        bus.req_last  = l;
        bus.f_full    = f;
        bus.f_wuse    = ASIZE'(wuse);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(4'b0, 4'b0, 1'b0, 0);
        bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        step();
        step();
        chk("reset_state", outs(), 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int beats, stall, nwr, bad, owner, rr, cnt, c, k, pos;
        logic [3:0] g, v, l;
        logic f, w;
        logic [31:0] e;
        int wuse;
        logic [7:0] wr_seq[$];

        // v, l, f, wuse | grant, busy, ready, wen, wdata
        tbl[0] = '{4'b0001, 4'b0000, 1'b0, 0,    4'b0000, 1'b0, 4'b0000, 1'b0, 10'h000};
        tbl[1] = '{4'b0001, 4'b0000, 1'b0, 0,    4'b0001, 1'b1, 4'b0001, 1'b1, 10'h0A0};
        tbl[2] = '{4'b0001, 4'b0000, 1'b0, 0,    4'b0001, 1'b1, 4'b0001, 1'b1, 10'h0A0};
        tbl[3] = '{4'b0001, 4'b0001, 1'b0, 0,    4'b0001, 1'b1, 4'b0001, 1'b1, 10'h0A0};
        tbl[4] = '{4'b0000, 4'b0000, 1'b0, 0,    4'b0000, 1'b0, 4'b0000, 1'b0, 10'h000};
        tbl[5] = '{4'b0010, 4'b0000, 1'b0, 1008, 4'b0000, 1'b0, 4'b0000, 1'b0, 10'h000};
        tbl[6] = '{4'b0010, 4'b0010, 1'b0, 1008, 4'b0010, 1'b1, 4'b0010, 1'b1, 10'h1A1};
        tbl[7] = '{4'b0010, 4'b0000, 1'b0, 1009, 4'b0000, 1'b0, 4'b0000, 1'b0, 10'h000};
        tbl[8] = '{4'b0010, 4'b0000, 1'b0, 1009, 4'b0000, 1'b0, 4'b0000, 1'b0, 10'h000};
        tbl[9] = '{4'b0000, 4'b0000, 1'b0, 0,    4'b0000, 1'b0, 4'b0000, 1'b0, 10'h000};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].l, tbl[i].f, tbl[i].wuse);
            #1;
            chk($sformatf("vec%0d", i), outs(), mk(tbl[i].g, tbl[i].b, tbl[i].r, tbl[i].w));
            if (tbl[i].w) chk($sformatf("vec%0d_wdata", i), 32'(bus.f_wdata), 32'(tbl[i].wd));
            step();
        end

        // All sources valid, never last: full-length bursts rotating 0,1,2,3,0.
        do_reset();
        drive(4'b1111, 4'b0000, 1'b0, 0);
        for (c = 0; c < 5 * (BURST + 1); c++) begin
            #1;
            e = 32'h0;
            if (c >= 1) begin
                k   = (c - 1) / (BURST + 1);
                pos = (c - 1) % (BURST + 1);
                if (pos < BURST) begin
                    g = 4'(1 << (k % NREQ));
                    e = mk(g, 1'b1, g, 1'b1);
                end
            end
            chk($sformatf("rotate_c%0d", c), outs(), e);
            step();
        end

        // f_full stall mid-burst; source advances its data only on acceptance.
        do_reset();
        beats = 0; stall = 0; nwr = 0; bad = 0;
        wr_seq.delete();
        for (c = 0; c < 40; c++) begin
            drive({3'b000, beats < BURST}, 4'b0000, (beats == 3 && stall < 5), 0);
            bus.req_data[7:0] = 8'(beats);
            #1;
            if (bus.f_full) begin
                chk($sformatf("stall%0d", stall), outs(), mk(4'b0001, 1'b1, 4'b0000, 1'b0));
                stall++;
            end
            w = bus.f_wen;
            if (w) wr_seq.push_back(bus.f_wdata[7:0]);
            step();
            if (w) beats++;
        end
        foreach (wr_seq[i]) if (wr_seq[i] != 8'(i)) bad++;
        chk("stall_beats", 32'(wr_seq.size()), 32'(BURST));
        chk("stall_order", 32'(bad), 32'h0);
        chk("stall_end_idle", outs(), 32'h0);
        bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        // Owner gaps without last while src2 waits: no preemption.
        do_reset();
        drive(4'b0101, 4'b0000, 1'b0, 0);
        #1; chk("hold_idle", outs(), 32'h0); step();
        for (int i = 0; i < 2; i++) begin
            #1; chk($sformatf("hold_beat%0d", i), outs(), mk(4'b0001, 1'b1, 4'b0001, 1'b1)); step();
        end
        drive(4'b0100, 4'b0000, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            #1; chk($sformatf("hold_gap%0d", i), outs(), mk(4'b0001, 1'b1, 4'b0001, 1'b0)); step();
        end
        drive(4'b0101, 4'b0001, 1'b0, 0);
        #1; chk("hold_last", outs(), mk(4'b0001, 1'b1, 4'b0001, 1'b1)); step();
        drive(4'b0100, 4'b0000, 1'b0, 0);
        #1; chk("hold_bubble", outs(), 32'h0); step();
        #1; chk("hold_src2", outs(), mk(4'b0100, 1'b1, 4'b0100, 1'b1));
        chk("hold_src2_wdata", 32'(bus.f_wdata), 32'h2A2);
        step();

        // Asynchronous reset in the middle of a burst.
        do_reset();
        drive(4'b0010, 4'b0000, 1'b0, 0);
        step();
        #1; chk("arst_pre", outs(), mk(4'b0010, 1'b1, 4'b0010, 1'b1));
        step();
        #2 rst_n = 1'b0;
        #1 chk("arst_async", outs(), 32'h0);
        step();
        rst_n = 1'b1;
        drive(4'b1111, 4'b0000, 1'b0, 0);
        #1; chk("arst_idle", outs(), 32'h0); step();
        #1; chk("arst_src0_wins", outs(), mk(4'b0001, 1'b1, 4'b0001, 1'b1)); step();

        // Randomized traffic against a reference model; owner=-1 means no grant.
        do_reset();
        owner = -1; rr = NREQ - 1; cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            v = 4'($urandom);
            l = 4'($urandom & $urandom);
            f = ($urandom % 5) == 0;
            wuse = (($urandom % 6) == 0) ? DEPTH - BURST - 1 + int'($urandom % 3) : int'($urandom % 600);
            drive(v, l, f, wuse);
            bus.req_data = $urandom;
            #1;
            w = 1'b0;
            if (owner < 0) e = 32'h0;
            else begin
                g = 4'(1 << owner);
                w = v[owner] && !f;
                e = mk(g, 1'b1, f ? 4'b0000 : g, w);
            end
            chk($sformatf("rand%0d", n), outs(), e);
            if (w) chk($sformatf("rand%0d_wdata", n), 32'(bus.f_wdata),
                       32'({2'(owner), bus.req_data[owner*DSIZE +: DSIZE]}));
            if (owner < 0) begin
                if (v != 0 && wuse + BURST <= DEPTH) begin
                    for (int i = 1; i <= NREQ && owner < 0; i++)
                        if (v[(rr + i) % NREQ]) owner = (rr + i) % NREQ;
                    cnt = 0;
                end
            end else if (w) begin
                cnt++;
                if (l[owner] || cnt == BURST) begin
                    rr = owner;
                    owner = -1;
                end
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
